// File: rtl/var_delay_line.sv
// var_delay_line: multi-lane delay line with valid tags, stall, flush and a runtime-selectable tap
// Ports: clk/rst (sync, active-high); en advances, flush clears all stages;
// cfg_load latches cfg_delay (clamped to MAX_DEPTH) into cur_delay and drops in-flight tags;
// in_valid/din in, out_valid/dout out (lane k at [k*DATA_WIDTH +: DATA_WIDTH]);
// empty = no valid tag in the active window s[0..cur_delay-1].
module var_delay_line #(
  parameter int DATA_WIDTH = 14,
  parameter int CHANNELS = 4,
  parameter int MAX_DEPTH = 8,
  localparam int DSW = $clog2(MAX_DEPTH + 1),
  localparam int W = CHANNELS * DATA_WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           flush,
  input  logic           cfg_load,
  input  logic [DSW-1:0] cfg_delay,
  input  logic           in_valid,
  input  logic [W-1:0]   din,
  output logic           out_valid,
  output logic [W-1:0]   dout,
  output logic [DSW-1:0] cur_delay,
  output logic           empty
);
  logic [W-1:0] data [MAX_DEPTH];
  logic [MAX_DEPTH-1:0] tag;
  logic [MAX_DEPTH-1:0] win;
  logic [W-1:0] tap_data;
  logic tap_valid;
  logic bypass;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MAX_DEPTH; i++) data[i] <= '0;
      tag <= '0;
      cur_delay <= DSW'(MAX_DEPTH);
    end else begin
      if (flush) begin
        for (int i = 0; i < MAX_DEPTH; i++) data[i] <= '0;
        tag <= '0;
      end else if (en) begin
        data[0] <= din;
        for (int i = 1; i < MAX_DEPTH; i++) data[i] <= data[i-1];
        // a retap drops everything already in flight but keeps the sample captured on this edge
        tag <= cfg_load ? MAX_DEPTH'(in_valid) : (tag << 1) | MAX_DEPTH'(in_valid);
      end else if (cfg_load) begin
        tag <= '0;
      end
      if (cfg_load) cur_delay <= cfg_delay > DSW'(MAX_DEPTH) ? DSW'(MAX_DEPTH) : cfg_delay;
    end
  end
  always_comb begin
    tap_valid = 1'b0;
    tap_data = '0;
    win = '0;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      win[i] = DSW'(i) < cur_delay;
      if (cur_delay == DSW'(i + 1)) begin
        tap_valid = tag[i];
        tap_data = data[i];
      end
    end
  end
  assign bypass = cur_delay == '0;
  assign out_valid = bypass ? in_valid & en : tap_valid;
  assign dout = out_valid ? (bypass ? din : tap_data) : '0;
  assign empty = ~|(tag & win);
endmodule
